rf_writeback_arb: RTL and testbench

//  Writer-side front end of the 32x32 RISC-V register file (2R/1W, x0 hardwired 0).

---
 rtl/rf_pkg.sv | 14 +
 rtl/wb_fifo.sv | 67 ++++++
 rtl/rf_writeback_arb.sv | 122 ++++++++++++
 tb/tb_rf_writeback_arb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types for the register-file writeback front end.
package rf_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;

  typedef logic [4:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       addr;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries; buffers LSU load data while
// the ALU owns the RF write port. DEPTH must be a power of two.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  wb_entry_t push_entry_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next pointers, occupancy and storage; pointers wrap naturally at DEPTH.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Control state: reset empties the queue, dropping any stale entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rf_writeback_arb.sv
// Writer-side front end of the register file: merges ALU and LSU results
// onto the single RF write port (ALU has priority) and keeps a busy
// scoreboard of outstanding loads to stall decode on RAW/WAW hazards.
module rf_writeback_arb
  import rf_pkg::*;
#(
  parameter int XLEN           = rf_pkg::XLEN,
  parameter int LSU_FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            alu_valid_i,
  input  logic [4:0]      alu_addr_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            lsu_valid_i,
  output logic            lsu_ready_o,
  input  logic [4:0]      lsu_addr_i,
  input  logic [XLEN-1:0] lsu_data_i,
  input  logic            load_issue_i,
  input  logic [4:0]      load_rd_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic            stall_o,
  output logic            write_enable_o,
  output logic [4:0]      write_addr_o,
  output logic [XLEN-1:0] write_data_o
);

  wb_entry_t           lsu_entry, fifo_head, sel_entry;
  logic                fifo_full, fifo_empty, fifo_push, fifo_pop, sel_valid;
  logic                we_q, we_d;
  reg_addr_t           waddr_q, waddr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic                src_lsu_q, src_lsu_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Ready is plain !full: a pop in the same cycle does not open a slot early.
  assign lsu_ready_o = ~fifo_full;
  assign fifo_push   = lsu_valid_i & lsu_ready_o;
  assign fifo_pop    = ~alu_valid_i & ~fifo_empty;
  assign lsu_entry   = '{addr: lsu_addr_i, data: lsu_data_i};

  wb_fifo #(
    .DEPTH(LSU_FIFO_DEPTH)
  ) u_lsu_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (fifo_push),
    .push_entry_i(lsu_entry),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  // Fixed-priority select: ALU result first, otherwise the FIFO head.
  always_comb begin
    sel_valid = alu_valid_i | ~fifo_empty;
    sel_entry = fifo_head;
    if (alu_valid_i) begin
      sel_entry = '{addr: alu_addr_i, data: alu_data_i};
    end
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    src_lsu_d = fifo_pop;
    if (sel_valid) begin
      // x0 writes still travel through (and drain the FIFO) but never enable.
      we_d    = (sel_entry.addr != '0);
      waddr_d = sel_entry.addr;
      wdata_d = sel_entry.data;
    end
  end

  // Scoreboard update: a load writeback clears, a newly issued load sets (set wins).
  always_comb begin
    busy_d = busy_q;
    if (we_q && src_lsu_q) begin
      busy_d[waddr_q] = 1'b0;
    end
    if (load_issue_i && (load_rd_i != '0)) begin
      busy_d[load_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // RAW on either source, or WAW on the rd of a load being issued.
  always_comb begin
    stall_o = busy_q[rs1_addr_i] | busy_q[rs2_addr_i] |
              (load_issue_i & busy_q[load_rd_i]);
  end

  // Write-port registers, source flag and busy vector.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      src_lsu_q <= 1'b0;
      busy_q    <= '0;
    end else begin
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      src_lsu_q <= src_lsu_d;
      busy_q    <= busy_d;
    end
  end

  assign write_enable_o = we_q;
  assign write_addr_o   = waddr_q;
  assign write_data_o   = wdata_q;

  // ALU must never target a register with a load still outstanding.
  a_alu_not_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (alu_valid_i && (alu_addr_i != '0)) |-> !busy_q[alu_addr_i]);

  // A load writeback must retire a register that was marked busy.
  a_lsu_was_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (we_q && src_lsu_q) |-> busy_q[waddr_q]);

endmodule

// File: tb/tb_rf_writeback_arb.sv
// Bench for rf_writeback_arb: a queue/array reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_rf_writeback_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_addr = '0;
  logic [31:0] lsu_data = '0;
  logic        load_issue = 1'b0;
  logic [4:0]  load_rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        stall;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rf_writeback_arb #(
    .XLEN          (32),
    .LSU_FIFO_DEPTH(2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .alu_valid_i   (alu_valid),
    .alu_addr_i    (alu_addr),
    .alu_data_i    (alu_data),
    .lsu_valid_i   (lsu_valid),
    .lsu_ready_o   (lsu_ready),
    .lsu_addr_i    (lsu_addr),
    .lsu_data_i    (lsu_data),
    .load_issue_i  (load_issue),
    .load_rd_i     (load_rd),
    .rs1_addr_i    (rs1),
    .rs2_addr_i    (rs2),
    .stall_o       (stall),
    .write_enable_o(we),
    .write_addr_o  (waddr),
    .write_data_o  (wdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: pending loads as a bit array, LSU buffer as a queue.
  typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  ent_t        m_e;
  logic [31:0] m_busy = '0;
  logic [31:0] m_nb;
  logic        m_we = 1'b0;
  logic        m_lsu = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  bit          m_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_busy = '0;
      m_we   = 1'b0;
      m_lsu  = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      m_rdy = (mq.size() < 2);
      m_nb  = m_busy;
      if (m_we && m_lsu) m_nb[m_addr] = 1'b0;
      if (load_issue && load_rd != 0) m_nb[load_rd] = 1'b1;
      if (alu_valid) begin
        m_addr = alu_addr; m_data = alu_data; m_we = (alu_addr != 0); m_lsu = 1'b0;
      end else if (mq.size() > 0) begin
        m_e = mq.pop_front();
        m_addr = m_e.a; m_data = m_e.d; m_we = (m_e.a != 0); m_lsu = 1'b1;
      end else begin
        m_we = 1'b0; m_lsu = 1'b0;
      end
      if (lsu_valid && m_rdy) mq.push_back('{a: lsu_addr, d: lsu_data});
      m_busy = m_nb;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_we", 64'(we), 64'(m_we));
    chk("m_waddr", 64'(waddr), 64'(m_addr));
    chk("m_wdata", 64'(wdata), 64'(m_data));
    chk("m_ready", 64'(lsu_ready), 64'(mq.size() < 2));
    chk("m_stall", 64'(stall),
        64'(m_busy[rs1] | m_busy[rs2] | (load_issue & m_busy[load_rd])));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_ready", 64'(lsu_ready), 64'd1);
    chk("rst_stall", 64'(stall), 64'd0);
    rst_n = 1'b1;
    step();

    // ALU only
    alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 0;
    chk("alu_we", 64'(we), 64'd1);
    chk("alu_addr", 64'(waddr), 64'd5);
    chk("alu_data", 64'(wdata), 64'hDEADBEEF);
    step();
    chk("alu_we_off", 64'(we), 64'd0);

    // RAW on a pending load
    load_issue = 1; load_rd = 7;
    step();
    load_issue = 0; rs1 = 7;
    settle();
    chk("raw_stall0", 64'(stall), 64'd1);
    step();
    chk("raw_stall1", 64'(stall), 64'd1);
    lsu_valid = 1; lsu_addr = 7; lsu_data = 32'h1234;
    step();
    lsu_valid = 0;
    chk("raw_we_wait", 64'(we), 64'd0);
    chk("raw_stall2", 64'(stall), 64'd1);
    step();
    chk("raw_we", 64'(we), 64'd1);
    chk("raw_addr", 64'(waddr), 64'd7);
    chk("raw_data", 64'(wdata), 64'h1234);
    chk("raw_stall3", 64'(stall), 64'd1);
    step();
    chk("raw_stall_drop", 64'(stall), 64'd0);
    rs1 = 0;

    // Contention: ALU wins, LSU follows
    load_issue = 1; load_rd = 4;
    step();
    load_issue = 0;
    alu_valid = 1; alu_addr = 3; alu_data = 32'hA;
    lsu_valid = 1; lsu_addr = 4; lsu_data = 32'hB;
    step();
    alu_valid = 0; lsu_valid = 0;
    chk("cont_addr0", 64'(waddr), 64'd3);
    chk("cont_data0", 64'(wdata), 64'hA);
    step();
    chk("cont_we1", 64'(we), 64'd1);
    chk("cont_addr1", 64'(waddr), 64'd4);
    chk("cont_data1", 64'(wdata), 64'hB);
    step();

    // FIFO full under continuous ALU traffic
    for (int i = 0; i < 3; i++) begin
      load_issue = 1; load_rd = 5'(10 + i);
      step();
    end
    load_issue = 0;
    alu_valid = 1; alu_addr = 20; alu_data = 32'h20;
    lsu_valid = 1; lsu_addr = 10; lsu_data = 32'h100;
    step();
    alu_addr = 21; alu_data = 32'h21;
    lsu_addr = 11; lsu_data = 32'h101;
    step();
    alu_addr = 22; alu_data = 32'h22;
    lsu_addr = 12; lsu_data = 32'h102;
    settle();
    chk("full_ready0", 64'(lsu_ready), 64'd0);
    step();
    alu_addr = 23; alu_data = 32'h23;
    step();
    chk("full_alu_addr", 64'(waddr), 64'd23);
    alu_valid = 0;
    settle();
    chk("full_pop_ready", 64'(lsu_ready), 64'd0);
    step();
    chk("drain_addr0", 64'(waddr), 64'd10);
    chk("drain_ready", 64'(lsu_ready), 64'd1);
    step();
    lsu_valid = 0;
    chk("drain_addr1", 64'(waddr), 64'd11);
    step();
    chk("drain_addr2", 64'(waddr), 64'd12);
    chk("drain_data2", 64'(wdata), 64'h102);
    step();

    // x0 handling
    alu_valid = 1; alu_addr = 0; alu_data = 32'h55;
    load_issue = 1; load_rd = 0;
    settle();
    chk("x0_stall", 64'(stall), 64'd0);
    step();
    alu_valid = 0; load_issue = 0;
    chk("x0_we", 64'(we), 64'd0);
    chk("x0_data", 64'(wdata), 64'h55);
    step();

    // Same rd: writeback and new load issue on the same edge
    load_issue = 1; load_rd = 9;
    step();
    load_issue = 0;
    lsu_valid = 1; lsu_addr = 9; lsu_data = 32'h99;
    step();
    lsu_valid = 0;
    step();
    chk("same_we", 64'(we), 64'd1);
    load_issue = 1; load_rd = 9;
    step();
    load_issue = 0; rs1 = 9;
    settle();
    chk("same_busy", 64'(stall), 64'd1);
    lsu_valid = 1; lsu_addr = 9; lsu_data = 32'h77;
    step();
    lsu_valid = 0;
    step();
    step();
    chk("same_clear", 64'(stall), 64'd0);
    rs1 = 0;

    // Reset mid-operation with queued data and busy bits
    load_issue = 1; load_rd = 13;
    step();
    load_rd = 14;
    step();
    load_issue = 0;
    alu_valid = 1; alu_addr = 25; alu_data = 32'h25;
    lsu_valid = 1; lsu_addr = 13; lsu_data = 32'h130;
    step();
    alu_addr = 26; alu_data = 32'h26;
    lsu_addr = 14; lsu_data = 32'h140;
    step();
    alu_addr = 27; alu_data = 32'h27;
    lsu_valid = 0; rs1 = 13;
    settle();
    chk("pre_rst_stall", 64'(stall), 64'd1);
    chk("pre_rst_ready", 64'(lsu_ready), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 64'(we), 64'd0);
    chk("mid_rst_ready", 64'(lsu_ready), 64'd1);
    chk("mid_rst_stall", 64'(stall), 64'd0);
    alu_valid = 0; rs1 = 0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_we", 64'(we), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
